wide_word_out_fifo_512: RTL and testbench
=========================================

# wide_word_out_fifo_512

Downstream buffer for the 512-bit word assembler in the compressor output path. It captures each completed 512-bit word the cycle the assembler's second half lands, queues it, and presents it to the memory-write side with a valid/ready handshake. It also tracks stream framing (last word, word count, completion pulse) and reports backpressure. The assembler cannot stall, so backpressure is advisory only (almost_full).

## Interface
- DEPTH, 16, word slots including output stage; power of two ≥ 4
- AW, 4, log2(DEPTH)
- AF_MARGIN, 4, almost_full asserts when occupancy ≥ DEPTH − AF_MARGIN
---
- clk  in  1  single clock, all logic posedge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  one completed word on in_data this cycle
- in_data  in  512  assembled word
- in_last  in  1  qualifies in_valid: final word of stream
- almost_full  out  1  registered occupancy threshold flag
- out_valid  out  1  word present on out_data
- out_data  out  512  head word
- out_last  out  1  head word is stream-final
- out_ready  in  1  consumer accepts head this cycle
- word_count  out  32  words accepted in current/most recent stream
- done  out  1  one-cycle pulse after final word popped
- err  out  1  sticky protocol/overflow flag (see Configuration)

## Operation
- Storage: DEPTH entries × 513 bits {last, data}; occupancy counts every stored word including the one on out_data.
- Push = in_valid && accepted; pop = out_valid && out_ready.
- FSM states IDLE, RUN, FLUSH:
  - IDLE → RUN on first in_valid; word_count loads 1 on that push.
  - RUN: each push increments word_count (wraps at 2^32); push with in_last → FLUSH.
  - FLUSH: in_valid is dropped (not stored, not counted), err set. FLUSH → IDLE on pop of the word with last=1; done pulses the next cycle.
  - IDLE with in_valid && in_last: single-word stream, IDLE → FLUSH directly, word_count = 1.
- Full (occupancy == DEPTH): push accepted only if a pop occurs the same cycle; otherwise word dropped, word_count unchanged, err set.
- Empty: out_valid = 0; out_data/out_last hold previous values.
- Pop and push same cycle at any occupancy: both take effect, occupancy unchanged.
- word_count holds its value in IDLE until next stream starts.
- Reset (any time, including mid-stream): all contents discarded, FSM → IDLE immediately.
- Reset values: out_valid 0, out_data 0, out_last 0, almost_full 0, word_count 0, done 0, err 0.

## Timing
- Latency: push in cycle N into empty buffer → out_valid = 1 in cycle N+1 with that word.
- Throughput: one push and one pop per cycle sustained.
- After pop in cycle N, next queued word on out_data in cycle N+1; out_valid stays high if occupancy > 0.
- out_data/out_valid stable while out_valid && !out_ready.
- almost_full and err registered: reflect state after the triggering edge (visible cycle N+1).
- done: high exactly one cycle, cycle N+1 after final-word pop in cycle N; FSM reads IDLE in N+1, so a new stream's in_valid in N+1 is accepted.

## Configuration
- WIDE_FIFO_ERR_CHK_EN defined: err logic present; set on dropped word (full without pop, or in_valid in FLUSH), cleared only by reset.
- Undefined: err tied 0; dropped words still dropped silently; all other behaviour identical.

## Test plan
- Single-word stream: reset released, cycle 0 in_valid=1, in_last=1, in_data=512'hA5…A5, out_ready=1 → out_valid=1 with A5…A5, out_last=1 in cycle 1; done=1 in cycle 2 only; word_count=1; err=0.
- Fill: out_ready=0, push 16 words 0..15 every other cycle → almost_full=1 the cycle after word 11 (occupancy 12); word 16 dropped; word_count=16; err=1 (macro on) / 0 (off); drain yields 0..15 in order.
- Full with simultaneous pop: occupancy 16, in_valid and out_ready both high → word accepted, occupancy stays 16, err=0, word_count increments.
- Streaming: 8 words 1..8 (last on 8) one per cycle, out_ready=1 → out_data 1..8 on consecutive cycles starting cycle 1, out_last only with 8, done once.
- FLUSH guard: after in_last pushed with out_ready=0, in_valid=1 data=0xDEAD → not output, word_count unchanged, err=1 (macro on).
- Reset mid-stream: 5 words queued, assert reset async mid-cycle → out_valid, word_count, almost_full, err 0 immediately; after release, new single-word stream behaves as scenario 1.

Source files
------------

// File: rtl/wide_word_out_fifo_512_if.sv
// Bus bundle for the 512-bit word output FIFO: assembler push side, memory-write pop side,
// framing/status outputs and an FSM state debug tap.
interface wide_word_out_fifo_512_if;
   logic         in_valid;
   logic [511:0] in_data;
   logic         in_last;
   logic         almost_full;
   logic         out_valid;
   logic [511:0] out_data;
   logic         out_last;
   logic         out_ready;
   logic [31:0]  word_count;
   logic         done;
   logic         err;
   logic [1:0]   dbg_state;

   // Handshake: a word moves out only in a cycle where out_valid && out_ready are both high;
   // out_valid/out_data/out_last never change while out_valid && !out_ready. The push side has
   // no ready: in_valid is a one-cycle strobe, and a word that cannot be stored is dropped.
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  almost_full, out_valid, out_data, out_last, word_count, done, err, dbg_state
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output almost_full, out_valid, out_data, out_last, word_count, done, err, dbg_state
   );
endinterface

// File: rtl/wide_word_out_fifo_512.sv
// Output buffer for assembled 512-bit words with stream framing and advisory backpressure.
// Optional sticky drop flag: define WIDE_FIFO_ERR_CHK_EN to build the err logic.
module wide_word_out_fifo_512 #(
   parameter int DEPTH     = 16,
   parameter int AW        = 4,
   parameter int AF_MARGIN = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   wide_word_out_fifo_512_if.slave  bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [512:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_mem_cnt;
   logic          r_out_valid;
   logic [511:0]  r_out_data;
   logic          r_out_last;
   logic          r_af;
   logic [31:0]   r_word_count;
   logic          r_done;

   logic          w_pop;
   logic          w_full;
   logic          w_accept;
   logic          w_out_load;
   logic          w_mem_rd;
   logic          w_bypass;
   logic          w_mem_wr;
   logic [AW:0]   w_occ;
   logic [AW:0]   w_occ_nxt;

   // Occupancy counts the output stage plus the words still waiting in the memory.
   assign w_occ      = r_mem_cnt + {{AW{1'b0}}, r_out_valid};
   assign w_pop      = r_out_valid && bus.out_ready;
   assign w_full     = (w_occ == (AW+1)'(DEPTH));
   assign w_accept   = bus.in_valid && (r_state != FLUSH) && (!w_full || w_pop);
   assign w_out_load = !r_out_valid || w_pop;
   assign w_mem_rd   = w_out_load && (r_mem_cnt != '0);
   assign w_bypass   = w_out_load && (r_mem_cnt == '0) && w_accept;
   assign w_mem_wr   = w_accept && !w_bypass;
   assign w_occ_nxt  = w_occ + {{AW{1'b0}}, w_accept} - {{AW{1'b0}}, w_pop};

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = bus.in_last ? FLUSH : RUN;
         RUN:     if (w_accept && bus.in_last) w_state_nxt = FLUSH;
         FLUSH:   if (w_pop && r_out_last) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (w_mem_wr) r_mem[r_wr_ptr] <= {bus.in_last, bus.in_data};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_mem_cnt <= '0;
      end else begin
         if (w_mem_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_mem_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_mem_wr, w_mem_rd})
            2'b10:   r_mem_cnt <= r_mem_cnt + (AW+1)'(1);
            2'b01:   r_mem_cnt <= r_mem_cnt - (AW+1)'(1);
            default: r_mem_cnt <= r_mem_cnt;
         endcase
      end
   end

   // Output stage refills from the memory first; an empty memory lets the input bypass straight in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else if (w_mem_rd) begin
         r_out_valid              <= 1'b1;
         {r_out_last, r_out_data} <= r_mem[r_rd_ptr];
      end else if (w_bypass) begin
         r_out_valid <= 1'b1;
         r_out_data  <= bus.in_data;
         r_out_last  <= bus.in_last;
      end else if (w_out_load) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_af         <= 1'b0;
         r_word_count <= '0;
         r_done       <= 1'b0;
      end else begin
         r_af   <= (w_occ_nxt >= (AW+1)'(DEPTH - AF_MARGIN));
         r_done <= (r_state == FLUSH) && w_pop && r_out_last;
         if (w_accept) r_word_count <= (r_state == IDLE) ? 32'd1 : r_word_count + 32'd1;
      end
   end

`ifdef WIDE_FIFO_ERR_CHK_EN
   logic r_err;
   logic w_drop;

   assign w_drop = bus.in_valid && !w_accept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_err <= 1'b0;
      else if (w_drop) r_err <= 1'b1;
   end

   assign bus.err = r_err;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.almost_full = r_af;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_data    = r_out_data;
   assign bus.out_last    = r_out_last;
   assign bus.word_count  = r_word_count;
   assign bus.done        = r_done;
   assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_wide_word_out_fifo_512.sv
// Bench for wide_word_out_fifo_512: directed framing/full/reset scenarios plus random traffic,
// all checked every cycle against a queue-based model of the buffer.
module tb_wide_word_out_fifo_512;
   localparam int DEPTH     = 16;
   localparam int AW        = 4;
   localparam int AF_MARGIN = 4;

   logic clk = 1'b0;
   logic reset;

   wide_word_out_fifo_512_if bus();

   wide_word_out_fifo_512 #(.DEPTH(DEPTH), .AW(AW), .AF_MARGIN(AF_MARGIN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard / model ----------------
   int           n_checks = 0;
   int           n_fail   = 0;
   logic [512:0] exp_q[$];
   int           m_mode;   // 0 idle, 1 in stream, 2 waiting for last word to leave
   logic [31:0]  m_count;
   logic         m_err;
   logic         m_done;
   logic [512:0] m_hold;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [511:0] rand_word();
      logic [511:0] w;
      for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom();
      return w;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_mode  = 0;
      m_count = '0;
      m_err   = 1'b0;
      m_done  = 1'b0;
      m_hold  = '0;
   endtask

   task automatic model_step();
      bit pop;
      bit acc;
      bit pop_last;
      pop      = (exp_q.size() > 0) && bus.out_ready;
      pop_last = pop && exp_q[0][512];
      acc      = bus.in_valid && (m_mode != 2) && ((exp_q.size() < DEPTH) || pop);
      m_done   = pop_last && (m_mode == 2);
`ifdef WIDE_FIFO_ERR_CHK_EN
      if (bus.in_valid && !acc) m_err = 1'b1;
`endif
      if (m_mode == 2 && pop_last) m_mode = 0;
      else if (acc) begin
         m_count = (m_mode == 0) ? 32'd1 : m_count + 32'd1;
         m_mode  = bus.in_last ? 2 : 1;
      end
      if (pop) m_hold = exp_q.pop_front();
      if (acc) exp_q.push_back({bus.in_last, bus.in_data});
   endtask

   always @(posedge clk) if (!reset) model_step();

   task automatic check_outputs();
      logic [512:0] head;
      head = (exp_q.size() > 0) ? exp_q[0] : m_hold;
      chk("out_valid",   bus.out_valid,   exp_q.size() > 0);
      chk("out_data",    bus.out_data,    head[511:0]);
      chk("out_last",    bus.out_last,    head[512]);
      chk("almost_full", bus.almost_full, exp_q.size() >= DEPTH - AF_MARGIN);
      chk("word_count",  bus.word_count,  m_count);
      chk("done",        bus.done,        m_done);
      chk("err",         bus.err,         m_err);
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle(input logic v, input logic [511:0] d, input logic l, input logic r);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_last   = l;
      bus.out_ready = r;
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic mid_cycle_reset();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("rst_out_valid",  bus.out_valid,   1'b0);
      chk("rst_word_count", bus.word_count,  32'd0);
      chk("rst_af",         bus.almost_full, 1'b0);
      chk("rst_err",        bus.err,         1'b0);
      @(negedge clk);
      check_outputs();
      reset = 1'b0;
   endtask

   task automatic single_word_stream();
      logic [511:0] a5;
      a5 = {64{8'hA5}};
      cycle(1'b1, a5, 1'b1, 1'b1);
      chk("t1_valid", bus.out_valid, 1'b1);
      chk("t1_data",  bus.out_data,  a5);
      chk("t1_last",  bus.out_last,  1'b1);
      chk("t1_done0", bus.done,      1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("t1_done1", bus.done,       1'b1);
      chk("t1_count", bus.word_count, 32'd1);
      chk("t1_err",   bus.err,        1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("t1_done2", bus.done,       1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs();
      reset = 1'b0;

      single_word_stream();

      // fill to capacity with the consumer stalled
      for (int k = 0; k < 16; k++) begin
         cycle(1'b1, 512'(k), 1'b0, 1'b0);
         if (k == 10) chk("fill_af_k10", bus.almost_full, 1'b0);
         if (k == 11) chk("fill_af_k11", bus.almost_full, 1'b1);
         cycle(1'b0, '0, 1'b0, 1'b0);
      end
      chk("fill_count", bus.word_count, 32'd16);
      // full with simultaneous pop: accepted
      cycle(1'b1, 512'd99, 1'b0, 1'b1);
      chk("fullpop_count", bus.word_count, 32'd17);
      chk("fullpop_err",   bus.err,        1'b0);
      chk("fullpop_af",    bus.almost_full, 1'b1);
      // full without pop: dropped
      cycle(1'b1, 512'd16, 1'b0, 1'b0);
      chk("drop_count", bus.word_count, 32'd17);
      repeat (17) cycle(1'b0, '0, 1'b0, 1'b1);
      cycle(1'b1, 512'd200, 1'b1, 1'b1);
      repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);

      // streaming 1..8
      for (int k = 1; k <= 8; k++) begin
         cycle(1'b1, 512'(k), k == 8, 1'b1);
         chk("stream_data", bus.out_data, 512'(k));
      end
      repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);

      // flush guard
      cycle(1'b1, 512'd7, 1'b0, 1'b0);
      cycle(1'b1, 512'd8, 1'b1, 1'b0);
      cycle(1'b1, 512'hDEAD, 1'b0, 1'b0);
      chk("flush_count", bus.word_count, 32'd2);
      repeat (4) cycle(1'b0, '0, 1'b0, 1'b1);

      // reset mid-stream
      for (int k = 0; k < 5; k++) cycle(1'b1, rand_word(), 1'b0, 1'b0);
      mid_cycle_reset();
      single_word_stream();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 799) == 0) mid_cycle_reset();
         else cycle($urandom_range(0, 99) < 60, rand_word(),
                    $urandom_range(0, 11) == 0,
                    $urandom_range(0, 99) < ((n / 200) % 2 == 0 ? 30 : 85));
      end
      repeat (40) cycle(1'b0, '0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
